// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine: shift/subtract iteration, error on zero operand.
// Optional cycle counter port enabled by defining GCD_CYCCNT_EN.
module gcd_stein #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error
`ifdef GCD_CYCCNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    localparam int unsigned KW = $clog2(WIDTH) + 1;

    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_params
    end

    typedef enum logic [2:0] {
        IDLE,
        STRIP,
        REDUCE,
        FINISH,
        ERR
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a_n;
    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] result_n;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_n;
    logic             done_n;
    logic             error_n;
    logic             zero_op;

    assign zero_op = (a_in == '0) || (b_in == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (start) state_n = zero_op ? ERR : STRIP;
            STRIP:  if (a[0] || b[0]) state_n = REDUCE;
            REDUCE: if (a == b) state_n = FINISH;
            FINISH: state_n = IDLE;
            ERR:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Result/done/error are computed one edge early so they land
    // together with entry into the FINISH/ERR done cycle.
    always_comb begin
        a_n      = a;
        b_n      = b;
        k_n      = k;
        result_n = result;
        error_n  = error;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    a_n = a_in;
                    b_n = b_in;
                    k_n = '0;
                    if (zero_op) begin
                        result_n = '0;
                        error_n  = 1'b1;
                        done_n   = 1'b1;
                    end
                end
            end
            STRIP: begin
                if (!a[0] && !b[0]) begin
                    a_n = a >> 1;
                    b_n = b >> 1;
                    k_n = k + 1'b1;
                end
            end
            REDUCE: begin
                if (a == b) begin
                    result_n = a << k;
                    error_n  = 1'b0;
                    done_n   = 1'b1;
                end else if (!a[0]) begin
                    a_n = a >> 1;
                end else if (!b[0]) begin
                    b_n = b >> 1;
                end else if (a > b) begin
                    a_n = a - b;
                end else begin
                    b_n = b - a;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a      <= '0;
            b      <= '0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            error  <= 1'b0;
        end else begin
            a      <= a_n;
            b      <= b_n;
            k      <= k_n;
            busy   <= (state_n != IDLE);
            done   <= done_n;
            result <= result_n;
            error  <= error_n;
        end
    end

`ifdef GCD_CYCCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= '0;
        end else if (state == IDLE && start) begin
            cycles <= CNT_W'(1);
        end else if ((state == STRIP || state == REDUCE) && cycles != '1) begin
            cycles <= cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// Scoreboard bench for gcd_stein: directed vectors, decoupled done monitor.
module tb_gcd_stein;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        error;
`ifdef GCD_CYCCNT_EN
    logic [15:0] cycles;
`endif

    gcd_stein #(.WIDTH(32), .CNT_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .error  (error)
`ifdef GCD_CYCCNT_EN
        ,
        .cycles (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
        int          t;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic e);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: busy=%0b required 0", busy);
        end
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        q.push_back('{a: a, b: b, r: r, e: e, t: cyc});
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            int   lat;
            exp_t x;
            chk("done_width", {63'd0, done_prev}, 64'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result=%0h required none", result);
            end else begin
                x   = q.pop_front();
                lat = cyc - x.t + 1;
                chk("result", {32'd0, result}, {32'd0, x.r});
                chk("error", {63'd0, error}, {63'd0, x.e});
                chk("busy_in_done", {63'd0, busy}, 64'd1);
                checks++;
                if (lat > 132 || lat < 1) begin
                    errors++;
                    $display("FAIL latency: got %0d required 1..132", lat);
                end
                if (x.e) chk("err_latency", 64'(lat), 64'd1);
`ifdef GCD_CYCCNT_EN
                chk("cycles", {48'd0, cycles}, 64'(lat));
`endif
            end
        end
        done_prev = rst_n && done;
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        rst_n = 1'b1;

        issue(32'd0, 32'd3, 32'd0, 1'b1);
        issue(32'd12, 32'd18, 32'd6, 1'b0);
        issue(32'd17, 32'd17, 32'd17, 1'b0);
        issue(32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
        issue(32'd5, 32'd0, 32'd0, 1'b1);
        issue(32'd0, 32'd0, 32'd0, 1'b1);
        issue(32'd64, 32'd48, 32'd16, 1'b0);
        issue(32'd35, 32'd14, 32'd7, 1'b0);
        issue(32'd13, 32'd7, 32'd1, 1'b0);

        issue(32'd48, 32'd36, 32'd12, 1'b0);
        repeat (3) @(negedge clk);
        a_in  = 32'd7;
        b_in  = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        issue(32'd1000, 32'd250, 32'd250, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(32'd9, 32'd6, 32'd3, 1'b0);
        issue(32'd100, 32'd75, 32'd25, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d required 0", q.size());
        end
        repeat (4) @(negedge clk);
        chk("hold_result", {32'd0, result}, 64'd25);
        chk("hold_error", {63'd0, error}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_done", {63'd0, done}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
